pipe_fft_dly_ctrl: RTL
======================

Name: pipe_fft_dly_ctrl

Overview:
- Sequencer for one pipelined-FFT delay-line RAM (single-clock dual-port micro-RAM, depth 2^ADDR_W, registered read).
- Generates wEn/wAddr/rAddr so the RAM acts as a DELAY-sample, valid-qualified FIFO delay.
- Produces rd_valid aligned to RAM read data, the SDF butterfly phase select, and a zero-fill flush sequence that drains the line at end of frame.
- Sits between a stage's input handshake and its butterfly; the RAM's wClk and rClk are both driven from clk.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2^ADDR_W.
DELAY, 32, delay in accepted samples; legal range 1..DEPTH-1; out-of-range values are a compile-time error.
RD_LAT, 2, RAM read latency in cycles from rAddr to valid rD; legal range 1..4.

Ports:
clk  in  1  single clock; drives RAM wClk and rClk.
nGrst  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear; same effect as reset.
in_valid  in  1  input sample valid.
in_ready  out  1  controller accepts a sample this cycle.
flush  in  1  single-cycle request to drain the line.
wEn  out  1  RAM write enable.
wAddr  out  ADDR_W  RAM write address.
rAddr  out  ADDR_W  RAM read address.
wdata_zero  out  1  datapath must write zero instead of input this cycle.
rd_valid  out  1  RAM rD holds a valid delayed sample.
bfly_sel  out  1  0 = load phase, 1 = butterfly phase.
fill_cnt  out  ADDR_W  number of valid samples in the line, saturates at DELAY.
busy  out  1  state is FILL, RUN or FLUSH.

Behaviour:
- Registered state: wptr[ADDR_W], fill_cnt, phase counter pcnt over 0..2*DELAY-1, flush counter fcnt, state, rd_valid shift register of length RD_LAT.
- Reset / clr values: state=IDLE, wptr=0, fill_cnt=0, pcnt=0, fcnt=0, shift register=0.
  - Resulting outputs: wEn=0, wAddr=0, rAddr=DEPTH-DELAY, rd_valid=0, bfly_sel=0, busy=0, in_ready=1, wdata_zero=0.
- Combinational outputs:
  - wAddr=wptr; rAddr=(wptr-DELAY) mod DEPTH.
  - in_ready = (state != FLUSH).
  - acc = in_valid & in_ready.
  - stb = acc | (state==FLUSH).
  - wEn = stb; wdata_zero = (state==FLUSH).
  - bfly_sel = (pcnt >= DELAY).
- On each stb:
  - wptr++ (wraps DEPTH-1 -> 0).
  - pcnt++ (wraps 2*DELAY-1 -> 0).
  - Shift register input = (fill_cnt == DELAY); otherwise shift in 0.
  - fill_cnt++ if fill_cnt < DELAY.
- rd_valid = shift register output: asserted exactly RD_LAT cycles after a strobe whose read slot held a written sample.
- Output ordering: delayed samples emerge in input order.
- Read and write never alias in the same cycle, because DELAY < DEPTH.
- State machine:
  - IDLE -> FILL on the first acc.
  - FILL -> RUN when fill_cnt reaches DELAY.
  - FILL or RUN -> FLUSH on flush (fcnt=0).
  - FLUSH: one stb every cycle; fcnt++. When fcnt == DELAY-1 on a stb, go to IDLE and set fill_cnt=0, pcnt=0. wptr is not reset.
  - flush in IDLE or FLUSH is ignored.
- Simultaneous flush and in_valid in FILL/RUN: that sample is accepted (in_ready is still 1 that cycle); FLUSH starts next cycle.
- in_valid during FLUSH: not accepted (in_ready=0), and the sample is not written.
- clr overrides all inputs.
- nGrst asserted mid-operation clears everything immediately, including in-flight rd_valid.

Test Plan:
- Defaults, reset, then 100 back-to-back samples (data = index 0..99):
  - First rd_valid occurs 2 cycles after the strobe of input 32 and carries sample 0.
  - 68 rd_valid pulses total, carrying 0..67 in order.
  - state reaches RUN after 32 samples.
- in_valid pattern 1,0,1,0 for 80 cycles (40 samples):
  - rd_valid pulses only 2 cycles after accepted strobes.
  - 8 outputs total, carrying 0..7.
  - wAddr holds during gaps.
- 200 continuous samples: wAddr wraps 63 -> 0; at wAddr=5, rAddr=37; no output sample lost or duplicated.
- bfly_sel on continuous input:
  - Rises after sample 32, falls after sample 64, rises after 96.
  - Returns to 0 after a completed flush.
- flush after 40 samples:
  - in_ready=0 and wdata_zero=1 for exactly 32 cycles; wEn=1 every one of those cycles.
  - rd_valid delivers samples 8..39; then IDLE, fill_cnt=0, busy=0.
  - An in_valid held high during the flush is not accepted.
- nGrst pulsed low at sample 50 while rd_valid is in flight: all outputs return to reset values immediately, with no rd_valid afterwards. A restream refills with a 32-sample latency again.

Source files
------------

// File: rtl/pipe_fft_dly_ctrl_if.sv
// Handshake and RAM-control bundle between a pipelined-FFT stage front end
// and its delay-line sequencer.
interface pipe_fft_dly_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              wEn;
    logic [ADDR_W-1:0] wAddr;
    logic [ADDR_W-1:0] rAddr;
    logic              wdata_zero;
    logic              rd_valid;
    logic              bfly_sel;
    logic [ADDR_W-1:0] fill_cnt;
    logic              busy;

    modport master (
        output in_valid, flush,
        input  in_ready, wEn, wAddr, rAddr, wdata_zero, rd_valid, bfly_sel, fill_cnt, busy
    );

    modport slave (
        input  in_valid, flush,
        output in_ready, wEn, wAddr, rAddr, wdata_zero, rd_valid, bfly_sel, fill_cnt, busy
    );
endinterface

// File: rtl/pipe_fft_dly_ctrl.sv
// Delay-line sequencer: turns a dual-port RAM into a DELAY-sample, valid-qualified
// FIFO delay with SDF butterfly phase select and a zero-fill end-of-frame flush.
module pipe_fft_dly_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DELAY  = 32,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               nGrst,
    input  logic               clr,
    pipe_fft_dly_ctrl_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PCNT_W = $clog2(2 * DELAY);

    generate
        if (DELAY < 1 || DELAY > DEPTH - 1) begin : gBadDelay
            $error("pipe_fft_dly_ctrl: DELAY must lie in 1..2**ADDR_W-1");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : gBadLat
            $error("pipe_fft_dly_ctrl: RD_LAT must lie in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t            stateReg;
    state_t            stateNext;
    logic [ADDR_W-1:0] wPtrReg;
    logic [ADDR_W-1:0] fillCntReg;
    logic [ADDR_W-1:0] fCntReg;
    logic [PCNT_W-1:0] pCntReg;
    logic              vldSrReg [RD_LAT];

    logic inFlush;
    logic acc;
    logic stb;
    logic lineFull;
    logic fillDone;
    logic flushDone;

    always_comb begin
        inFlush   = (stateReg == FLUSH);
        acc       = bus.in_valid & ~inFlush;
        stb       = acc | inFlush;
        lineFull  = (fillCntReg == ADDR_W'(DELAY));
        fillDone  = (fillCntReg == ADDR_W'(DELAY - 1));
        flushDone = inFlush & (fCntReg == ADDR_W'(DELAY - 1));
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            stateReg <= IDLE;
        end else if (clr) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A sample arriving together with flush is still taken; the drain starts next cycle.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (acc) stateNext = fillDone ? RUN : FILL;
            FILL: begin
                if (bus.flush)            stateNext = FLUSH;
                else if (acc && fillDone) stateNext = RUN;
            end
            RUN:     if (bus.flush) stateNext = FLUSH;
            FLUSH:   if (flushDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = ~inFlush;
        bus.wEn        = stb;
        bus.wdata_zero = inFlush;
        bus.wAddr      = wPtrReg;
        bus.rAddr      = wPtrReg - ADDR_W'(DELAY);
        bus.bfly_sel   = (pCntReg >= PCNT_W'(DELAY));
        bus.fill_cnt   = fillCntReg;
        bus.busy       = (stateReg != IDLE);
        bus.rd_valid   = vldSrReg[RD_LAT-1];
    end

    // The write pointer keeps running across frames; only the fill and phase restart.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            wPtrReg    <= '0;
            fillCntReg <= '0;
            pCntReg    <= '0;
            fCntReg    <= '0;
        end else if (clr) begin
            wPtrReg    <= '0;
            fillCntReg <= '0;
            pCntReg    <= '0;
            fCntReg    <= '0;
        end else begin
            if (stb) begin
                wPtrReg <= wPtrReg + 1'b1;
                pCntReg <= (pCntReg == PCNT_W'(2 * DELAY - 1)) ? '0 : pCntReg + 1'b1;
                if (!lineFull) fillCntReg <= fillCntReg + 1'b1;
            end
            if (inFlush) fCntReg <= fCntReg + 1'b1;
            if (flushDone) begin
                fCntReg    <= '0;
                fillCntReg <= '0;
                pCntReg    <= '0;
            end
        end
    end

    // Valid tag travels alongside the RAM read pipeline so it lines up with rD.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : gVld
        if (gi == 0) begin : gHead
            always_ff @(posedge clk or negedge nGrst) begin
                if (!nGrst)     vldSrReg[gi] <= 1'b0;
                else if (clr)   vldSrReg[gi] <= 1'b0;
                else            vldSrReg[gi] <= stb & lineFull;
            end
        end else begin : gTail
            always_ff @(posedge clk or negedge nGrst) begin
                if (!nGrst)     vldSrReg[gi] <= 1'b0;
                else if (clr)   vldSrReg[gi] <= 1'b0;
                else            vldSrReg[gi] <= vldSrReg[gi-1];
            end
        end
    end
endmodule
